// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared FSM encoding, access-type codes and address decode default
package bus_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [2:0] T_B  = 3'b000;
   localparam logic [2:0] T_H  = 3'b001;
   localparam logic [2:0] T_W  = 3'b010;
   localparam logic [2:0] T_BU = 3'b100;
   localparam logic [2:0] T_HU = 3'b101;

   localparam logic [3:0] IO_SEL_DEF = 4'h1;

endpackage

// File: rtl/bus_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; last=1 means master 1 was granted most recently
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   assign grant[0] = req[0] & (~req[1] | last);
   assign grant[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master single-slave-port arbiter with RAM/GPIO decode and registered strobes/acks
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned RD_LAT = 1,
   parameter logic [3:0]  IO_SEL = IO_SEL_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [2:0]  m0_type,
   input  logic [31:0] m0_wdata,
   output logic        m0_ack,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [2:0]  m1_type,
   input  logic [31:0] m1_wdata,
   output logic        m1_ack,
   output logic [31:0] rdata,
   output logic        ram_we,
   output logic        io_we,
   output logic [31:0] s_addr,
   output logic [2:0]  s_type,
   output logic [31:0] s_wdata,
   input  logic [31:0] ram_rdata,
   input  logic [31:0] io_rdata
);

   state_t      state_q, state_d;
   logic        last_q, last_d, id_q, id_d, we_q, we_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [2:0]  type_q, type_d, cnt_q, cnt_d;
   logic        ram_we_q, ram_we_d, io_we_q, io_we_d;
   logic        ack0_q, ack0_d, ack1_q, ack1_d;
   logic [1:0]  grant;
   logic        win_we, win_io, is_io, unused_addr;
   logic [31:0] win_addr, win_wdata;
   logic [2:0]  win_type;

   rr_arb2 u_rr (
      .req   ({m1_req, m0_req}),
      .last  (last_q),
      .grant (grant)
   );

   assign win_we      = grant[1] ? m1_we : m0_we;
   assign win_addr    = grant[1] ? m1_addr : m0_addr;
   assign win_type    = grant[1] ? m1_type : m0_type;
   assign win_wdata   = grant[1] ? m1_wdata : m0_wdata;
   assign win_io      = win_addr[31:28] == IO_SEL;
   assign is_io       = addr_q[31:28] == IO_SEL;
   assign unused_addr = ^addr_q[27:24];

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      id_d     = id_q;
      we_d     = we_q;
      addr_d   = addr_q;
      type_d   = type_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      cnt_d    = cnt_q;
      ram_we_d = 1'b0;
      io_we_d  = 1'b0;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      case (state_q)
         S_IDLE: if (|grant) begin
            state_d  = S_ACCESS;
            id_d     = grant[1];
            last_d   = grant[1];
            we_d     = win_we;
            addr_d   = win_addr;
            type_d   = win_type;
            wdata_d  = win_wdata;
            ram_we_d = win_we & ~win_io;
            io_we_d  = win_we & win_io;
         end
         // writes finish here; reads arm the latency counter
         S_ACCESS: begin
            state_d = we_q ? S_DONE : S_WAIT;
            cnt_d   = 3'(RD_LAT - 1);
            ack0_d  = we_q & ~id_q;
            ack1_d  = we_q & id_q;
         end
         S_WAIT: if (cnt_q == 3'd0) begin
            state_d = S_DONE;
            rdata_d = is_io ? io_rdata : ram_rdata;
            ack0_d  = ~id_q;
            ack1_d  = id_q;
         end else begin
            cnt_d = cnt_q - 3'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         last_q   <= 1'b1;
         id_q     <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         type_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         cnt_q    <= '0;
         ram_we_q <= 1'b0;
         io_we_q  <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         id_q     <= id_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         type_q   <= type_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         cnt_q    <= cnt_d;
         ram_we_q <= ram_we_d;
         io_we_q  <= io_we_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
      end
   end

   assign m0_ack  = ack0_q;
   assign m1_ack  = ack1_q;
   assign ram_we  = ram_we_q;
   assign io_we   = io_we_q;
   assign rdata   = rdata_q;
   assign s_addr  = {8'h00, addr_q[23:0]};
   assign s_type  = type_q;
   assign s_wdata = wdata_q;

endmodule
